// File: rtl/snn_input_loader.sv
// snn_input_loader
//
// Control stage between the UART receiver and the SNN datapath.
//
// It unpacks NUM_BYTES received bytes, LSB first, into NUM_BYTES*8 one-bit
// writes to the input RAM. Byte k bit i is written to address 8k+i. It then
// pulses start to the SNN core. While the core runs, the block hands
// input-RAM address control to the core. When the core pulses done, the
// block latches the classified digit and sends it back through the UART
// transmitter.
//
// Build option:
//   SNN_ASCII_TX_EN  defined   : tx_data = 8'h30 + latched digit (ASCII '0'..'9')
//                    undefined : tx_data = {4'b0000, latched digit}
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx_rdy     one-cycle pulse, rx_data valid
//   rx_data    received byte
//   ram_data   pixel bit to input RAM
//   ram_addr   input RAM address (loader address or core_addr)
//   ram_we     input RAM write enable
//   core_addr  read address from the SNN core
//   start      one-cycle start pulse to the SNN core
//   done       one-cycle pulse from the core, digit valid
//   digit      classification result from the core
//   tx_rdy     UART TX idle
//   tx_start   one-cycle pulse, send tx_data
//   tx_data    byte to transmit
//   led_digit  last latched result
//   busy       high in every state except WAIT_BYTE
//
// state     | meaning
// ----------+--------------------------------------------------------
// WAIT_BYTE | idle between bytes; accepts the next rx byte
// WRITE     | 8 cycles, one pixel bit written per cycle
// START     | one-cycle start pulse to the SNN core
// RUN       | core owns ram_addr; waits for done
// SEND      | waits for tx_rdy, then pulses tx_start once

module snn_input_loader #(
   parameter int NUM_BYTES = 98,
   parameter int ADDR_W    = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_rdy,
   input  logic [7:0]        rx_data,
   output logic              ram_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   input  logic [ADDR_W-1:0] core_addr,
   output logic              start,
   input  logic              done,
   input  logic [3:0]        digit,
   input  logic              tx_rdy,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic [3:0]        led_digit,
   output logic              busy
);

   localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

   localparam logic [2:0] S_WAIT_BYTE = 3'd0;
   localparam logic [2:0] S_WRITE     = 3'd1;
   localparam logic [2:0] S_START     = 3'd2;
   localparam logic [2:0] S_RUN       = 3'd3;
   localparam logic [2:0] S_SEND      = 3'd4;

   logic [2:0]        state;
   logic [7:0]        sr;
   logic [CNT_W-1:0]  byte_cnt;
   logic [2:0]        bit_cnt;
   logic [ADDR_W-1:0] loader_addr;
   logic [7:0]        tx_byte;

   // {byte_cnt, bit_cnt} is the same value as {byte_cnt, 3'b000} + bit_cnt.
   assign loader_addr = ADDR_W'({byte_cnt, bit_cnt});

`ifdef SNN_ASCII_TX_EN
   assign tx_byte = 8'h30 + {4'b0000, led_digit};
`else
   assign tx_byte = {4'b0000, led_digit};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_WAIT_BYTE;
         sr        <= 8'h00;
         byte_cnt  <= '0;
         bit_cnt   <= 3'd0;
         led_digit <= 4'd0;
      end else begin
         case (state)
            S_WAIT_BYTE: begin
               if (rx_rdy) begin
                  sr      <= rx_data;
                  bit_cnt <= 3'd0;
                  state   <= S_WRITE;
               end
            end
            S_WRITE: begin
               // rx_rdy is ignored here. A byte that arrives while its
               // predecessor is still being unpacked is dropped on purpose.
               if (bit_cnt == 3'd7) begin
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt <= '0;
                     state    <= S_START;
                  end else begin
                     byte_cnt <= byte_cnt + CNT_W'(1);
                     state    <= S_WAIT_BYTE;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
            S_START: begin
               state <= S_RUN;
            end
            S_RUN: begin
               if (done) begin
                  led_digit <= digit;
                  state     <= S_SEND;
               end
            end
            S_SEND: begin
               if (tx_rdy) begin
                  state <= S_WAIT_BYTE;
               end
            end
            default: begin
               state <= S_WAIT_BYTE;
            end
         endcase
      end
   end

   always_comb begin
      ram_we   = 1'b0;
      ram_data = 1'b0;
      ram_addr = '0;
      start    = 1'b0;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      case (state)
         S_WRITE: begin
            ram_we   = 1'b1;
            ram_data = sr[bit_cnt];
            ram_addr = loader_addr;
         end
         S_START: begin
            start = 1'b1;
         end
         S_RUN: begin
            ram_addr = core_addr;
         end
         S_SEND: begin
            ram_addr = core_addr;
            tx_start = tx_rdy;
            tx_data  = tx_byte;
         end
         default: begin
         end
      endcase
   end

   assign busy = (state != S_WAIT_BYTE);

endmodule

// File: tb/tb_snn_input_loader.sv
module tb_snn_input_loader;

   localparam int NUM_BYTES = 98;
   localparam int ADDR_W    = 10;
   localparam int NPIX      = NUM_BYTES * 8;

`ifdef SNN_ASCII_TX_EN
   localparam logic [7:0] TX7 = 8'h37;
   localparam logic [7:0] TX9 = 8'h39;
`else
   localparam logic [7:0] TX7 = 8'h07;
   localparam logic [7:0] TX9 = 8'h09;
`endif

   logic              clk;
   logic              rst;
   logic              rx_rdy;
   logic [7:0]        rx_data;
   logic              ram_data;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [ADDR_W-1:0] core_addr;
   logic              start;
   logic              done;
   logic [3:0]        digit;
   logic              tx_rdy;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic [3:0]        led_digit;
   logic              busy;

   snn_input_loader #(.NUM_BYTES(NUM_BYTES), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_rdy    (rx_rdy),
      .rx_data   (rx_data),
      .ram_data  (ram_data),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .core_addr (core_addr),
      .start     (start),
      .done      (done),
      .digit     (digit),
      .tx_rdy    (tx_rdy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .led_digit (led_digit),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   // scoreboard
   int         exp_addr_q[$];
   logic       exp_data_q[$];
   logic [7:0] exp_tx_q[$];
   int         exp_start   = 0;
   int         wr_total    = 0;
   int         start_total = 0;
   int         tx_total    = 0;
   logic       prev_we     = 1'b0;
   logic       mem [0:NPIX-1];
   int         img_idx     = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // monitor: samples on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (ram_we) begin
         wr_total++;
         if (exp_addr_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0d data %0b, expected no write", ram_addr, ram_data);
         end else begin
            int   ea;
            logic ed;
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            check("wr_addr", 32'(ram_addr), 32'(ea));
            check("wr_data", 32'(ram_data), 32'(ed));
         end
         if (int'(ram_addr) < NPIX) mem[ram_addr] = ram_data;
      end
      if (start) begin
         start_total++;
         if (exp_start == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_start: got start=1, expected 0");
         end else begin
            exp_start--;
            check("start_after_last_write", 32'(prev_we), 32'd1);
         end
      end
      if (tx_start) begin
         tx_total++;
         if (exp_tx_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_tx_start: got tx_data %0h, expected no tx_start", tx_data);
         end else begin
            logic [7:0] et;
            et = exp_tx_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(et));
         end
      end
      prev_we = ram_we;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ram_we"},    32'(ram_we),    32'd0);
      check({tag, "_ram_data"},  32'(ram_data),  32'd0);
      check({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
      check({tag, "_start"},     32'(start),     32'd0);
      check({tag, "_tx_start"},  32'(tx_start),  32'd0);
      check({tag, "_tx_data"},   32'(tx_data),   32'd0);
      check({tag, "_led_digit"}, 32'(led_digit), 32'd0);
      check({tag, "_busy"},      32'(busy),      32'd0);
   endtask

   // Called just after a rising edge with the DUT in WAIT_BYTE. inj >= 0
   // places an extra (to-be-dropped) rx_rdy pulse in WRITE cycle inj.
   task automatic send_byte(input logic [7:0] b, input int gap, input int inj);
      rx_data = b;
      rx_rdy  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         exp_addr_q.push_back(img_idx * 8 + i);
         exp_data_q.push_back(b[i]);
      end
      if (img_idx == NUM_BYTES - 1) begin
         exp_start++;
         img_idx = 0;
      end else begin
         img_idx++;
      end
      tick(1);
      rx_rdy = 1'b0;
      if (inj >= 0) begin
         tick(inj);
         rx_data = 8'hFF;
         rx_rdy  = 1'b1;
         tick(1);
         rx_rdy  = 1'b0;
         tick(gap - inj - 1);
      end else begin
         tick(gap);
      end
   endtask

   task automatic pulse_rx(input logic [7:0] b);
      rx_data = b;
      rx_rdy  = 1'b1;
      tick(1);
      rx_rdy  = 1'b0;
   endtask

   task automatic print_summary();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
   endtask

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: got timeout, expected completion");
      print_summary();
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      rx_rdy    = 1'b0;
      rx_data   = 8'h00;
      core_addr = '0;
      done      = 1'b0;
      digit     = 4'd0;
      tx_rdy    = 1'b0;
      tick(3);
      check_idle("reset");
      rst = 1'b0;
      tick(1);

      // Image 1: 0xA5 everywhere, with dropped pulses mid-WRITE and on the last WRITE cycle.
      for (int k = 0; k < NUM_BYTES; k++) begin
         send_byte(8'hA5, 20, (k == 10) ? 3 : ((k == 20) ? 7 : -1));
      end
      check("img1_writes",      32'(wr_total),          32'd784);
      check("img1_start_count", 32'(start_total),       32'd1);
      check("img1_queue_empty", 32'(exp_addr_q.size()), 32'd0);
      check("img1_busy",        32'(busy),              32'd1);
      check("img1_mem0",        32'(mem[0]),            32'd1);
      check("img1_mem1",        32'(mem[1]),            32'd0);
      check("img1_mem2",        32'(mem[2]),            32'd1);
      check("img1_mem5",        32'(mem[5]),            32'd1);
      check("img1_mem783",      32'(mem[783]),          32'd1);

      // RUN: core owns the address, no writes.
      core_addr = 10'd300;
      tick(1);
      check("run_ram_addr", 32'(ram_addr), 32'd300);
      check("run_ram_we",   32'(ram_we),   32'd0);
      pulse_rx(8'h11);
      tick(2);

      digit = 4'd7;
      done  = 1'b1;
      tick(1);
      done  = 1'b0;
      digit = 4'd2;
      check("led_after_done", 32'(led_digit), 32'd7);

      // SEND with tx_rdy low: hold without transmitting.
      for (int c = 0; c < 50; c++) begin
         if (c == 25) pulse_rx(8'h22);
         else tick(1);
         check("send_hold_tx_start", 32'(tx_start), 32'd0);
         check("send_hold_busy",     32'(busy),     32'd1);
      end
      check("send_ram_addr", 32'(ram_addr), 32'd300);

      exp_tx_q.push_back(TX7);
      tx_rdy = 1'b1;
      tick(1);
      tx_rdy = 1'b0;
      check("tx_count_1",      32'(tx_total),        32'd1);
      check("tx_queue_empty",  32'(exp_tx_q.size()), 32'd0);
      check("busy_after_send", 32'(busy),            32'd0);

      // done while idle is ignored.
      digit = 4'd3;
      done  = 1'b1;
      tick(1);
      done  = 1'b0;
      tick(2);
      check("idle_done_led",  32'(led_digit), 32'd7);
      check("idle_done_tx",   32'(tx_total),  32'd1);
      check("idle_done_busy", 32'(busy),      32'd0);

      // Image 2: aborted by reset after 40 bytes.
      for (int k = 0; k < 40; k++) begin
         send_byte(8'hFF, 12, -1);
      end
      check("partial_writes", 32'(wr_total), 32'd1104);
      rst = 1'b1;
      tick(2);
      check_idle("midreset");
      rst     = 1'b0;
      img_idx = 0;
      tick(3);
      check("midreset_no_writes", 32'(wr_total), 32'd1104);

      // Image 3: first byte 0x81, then 0x5A.
      for (int k = 0; k < NUM_BYTES; k++) begin
         send_byte((k == 0) ? 8'h81 : 8'h5A, 12, -1);
      end
      check("img3_writes",      32'(wr_total),          32'd1888);
      check("img3_start_count", 32'(start_total),       32'd2);
      check("img3_queue_empty", 32'(exp_addr_q.size()), 32'd0);
      check("img3_mem0",        32'(mem[0]),            32'd1);
      check("img3_mem1",        32'(mem[1]),            32'd0);
      check("img3_mem6",        32'(mem[6]),            32'd0);
      check("img3_mem7",        32'(mem[7]),            32'd1);
      check("img3_mem8",        32'(mem[8]),            32'd0);
      check("img3_mem9",        32'(mem[9]),            32'd1);

      // done with tx already idle: immediate single transmit.
      tx_rdy = 1'b1;
      exp_tx_q.push_back(TX9);
      digit = 4'd9;
      done  = 1'b1;
      tick(1);
      done  = 1'b0;
      tick(2);
      check("led_digit_9",    32'(led_digit),       32'd9);
      check("tx_count_2",     32'(tx_total),        32'd2);
      check("tx_queue_final", 32'(exp_tx_q.size()), 32'd0);
      check("final_busy",     32'(busy),            32'd0);
      check("start_pending",  32'(exp_start),       32'd0);

      print_summary();
      $finish;
   end

endmodule

// File: doc/snn_input_loader.md
Name: snn_input_loader

Overview:
Control stage between the UART receiver and the SNN datapath. Unpacks 98 received bytes into 784 one-bit pixel writes to the input RAM, then starts the SNN core. Waits for the core's done, latches the classified digit and sends it back via the UART transmitter. While the core runs, the block hands input-RAM address control to the core.

Parameters:
NUM_BYTES, 98, bytes per image (8 pixels per byte)
ADDR_W, 10, input RAM address width (must hold NUM_BYTES*8-1)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
rx_rdy  in  1  one-cycle pulse: rx_data valid
rx_data  in  8  received byte
ram_data  out  1  pixel bit to input RAM
ram_addr  out  ADDR_W  input RAM address (muxed loader/core)
ram_we  out  1  input RAM write enable
core_addr  in  ADDR_W  read address driven by SNN core
start  out  1  one-cycle start pulse to SNN core
done  in  1  one-cycle pulse from core: digit valid
digit  in  4  classification result from core
tx_rdy  in  1  UART TX idle
tx_start  out  1  one-cycle pulse: send tx_data
tx_data  out  8  byte to transmit
led_digit  out  4  last latched result
busy  out  1  high in any state except WAIT_BYTE

Behaviour:
- Reset values: state=WAIT_BYTE; byte_cnt=0; bit_cnt=0; ram_we=0, ram_data=0, start=0, tx_start=0, tx_data=0, led_digit=0, busy=0.
- Reset asserted mid-operation: same values on the next edge. Partial image is discarded and no further RAM write occurs.
- States: WAIT_BYTE, WRITE, START, RUN, SEND.
- WAIT_BYTE:
  - On rx_rdy, latch rx_data into shift register sr, set bit_cnt=0, go to WRITE.
- WRITE (8 cycles):
  - ram_we=1, ram_addr={byte_cnt,3'b000}+bit_cnt, ram_data=sr[bit_cnt] (LSB first).
  - Byte k bit i is written to address 8k+i.
  - bit_cnt==7: if byte_cnt==NUM_BYTES-1, clear byte_cnt and go to START; otherwise increment byte_cnt and go to WAIT_BYTE.
- Latency: rx_rdy at edge t gives first write during cycle t+1 and last write during t+8.
- START: start=1 for exactly one cycle, then RUN.
- RUN:
  - ram_we=0 and ram_addr=core_addr.
  - On done, led_digit<=digit, go to SEND.
- SEND:
  - Hold while tx_rdy=0.
  - When tx_rdy=1: tx_start=1 for one cycle, tx_data per Optional Feature, go to WAIT_BYTE.
- ram_addr mux:
  - WAIT_BYTE/WRITE/START: loader address; value is 0 outside WRITE.
  - RUN/SEND: core_addr.
- ram_we is asserted only in WRITE.
- rx_rdy in any state other than WAIT_BYTE is dropped (no buffering). The byte count is unaffected.
- done outside RUN is ignored. led_digit holds until the next done in RUN.
- rx_rdy and the last WRITE cycle coinciding: byte dropped, transition proceeds normally.

Optional Feature:
SNN_ASCII_TX_EN
- Defined: tx_data = 8'h30 + {4'b0,led_digit value latched}, so digit 7 is sent as 8'h37 ('7').
- Undefined: tx_data = {4'b0000, digit}, so digit 7 is sent as 8'h07.

Test Plan:
- Reset then 98 bytes of 8'hA5 with gaps ≥20 cycles -> 784 writes. Address 0 gets 1, 1 gets 0, 2 gets 1, 5 gets 1, 783 gets 1. Single start pulse one cycle after the last write. busy=1.
- In RUN, core_addr=10'd300 -> ram_addr=300, ram_we=0. Then done with digit=4'd7 -> led_digit=7. With tx_rdy=1, tx_start pulses once with tx_data=8'h37 (macro defined) or 8'h07 (undefined).
- tx_rdy held 0 for 50 cycles after done -> tx_start stays 0 and state stays SEND. tx_rdy=1 -> exactly one tx_start pulse, then busy=0.
- rx_rdy pulses during WRITE, RUN and SEND -> no extra writes. The next image still begins at address 0 after SEND.
- rst=1 after 40 bytes, then 98 new bytes -> first new byte written to addresses 0..7. Exactly one start pulse, after byte 98.
- done pulsed in WAIT_BYTE with digit=3 -> led_digit unchanged, no tx_start.
